syn_syscall: RTL and testbench

SYN_SYSCALL -- requirements
Module: syn_syscall

---
 rtl/syn_syscall.sv | 124 ++++++++++++
 tb/tb_syn_syscall.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/syn_syscall.sv
// Syscall retire unit: decodes the service code at retire, stalls the
// pipeline for display / pause / exit services and counts accepted syscalls.
module syn_syscall #(
  parameter int DISP_HOLD = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             resume,
  output logic             stall,
  output logic             halted,
  output logic [31:0]      disp_val,
  output logic             disp_we,
  output logic [CNT_W-1:0] sys_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DISP  = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_PRINT_HEX = 32'd34;
  localparam logic [31:0] SVC_EXIT      = 32'd10;
  localparam logic [31:0] SVC_PAUSE     = 32'd50;
  localparam logic [7:0]  HOLD_INIT     = 8'(DISP_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             stall_q, stall_d;
  logic             halted_q, halted_d;
  logic [31:0]      disp_val_q, disp_val_d;
  logic             disp_we_q, disp_we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and next-output decode; only IDLE accepts a syscall.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stall_d    = stall_q;
    halted_d   = halted_q;
    disp_val_d = disp_val_q;
    disp_we_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (v0 == SVC_EXIT) begin
            state_d  = HALT;
            stall_d  = 1'b1;
            halted_d = 1'b1;
          end else if (v0 == SVC_PRINT_INT || v0 == SVC_PRINT_HEX) begin
            state_d    = DISP;
            disp_val_d = a0;
            disp_we_d  = 1'b1;
            hold_d     = HOLD_INIT;
            stall_d    = 1'b1;
          end else if (v0 == SVC_PAUSE) begin
            state_d = PAUSE;
            stall_d = 1'b1;
          end
        end
      end
      DISP: begin
        // hold_q counts the remaining stalled cycles after the current one
        if (hold_q == 8'd0) begin
          state_d = IDLE;
          stall_d = 1'b0;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      PAUSE: begin
        if (resume) begin
          state_d = IDLE;
          stall_d = 1'b0;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= 8'd0;
      stall_q    <= 1'b0;
      halted_q   <= 1'b0;
      disp_val_q <= 32'd0;
      disp_we_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      stall_q    <= stall_d;
      halted_q   <= halted_d;
      disp_val_q <= disp_val_d;
      disp_we_q  <= disp_we_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stall    = stall_q;
  assign halted   = halted_q;
  assign disp_val = disp_val_q;
  assign disp_we  = disp_we_q;
  assign sys_cnt  = cnt_q;

endmodule

// File: tb/tb_syn_syscall.sv
// Directed bench for syn_syscall: display, pause, exit, plain counting,
// counter saturation (second instance with CNT_W=2) and async reset.
module tb_syn_syscall;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        resume;

  logic        stall, halted, disp_we;
  logic [31:0] disp_val;
  logic [15:0] sys_cnt;

  logic        stall2, halted2, disp_we2;
  logic [31:0] disp_val2;
  logic [1:0]  sys_cnt2;

  int total;
  int bad;
  int nst;

  syn_syscall #(.DISP_HOLD(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .v0(v0), .a0(a0), .resume(resume),
    .stall(stall), .halted(halted), .disp_val(disp_val), .disp_we(disp_we),
    .sys_cnt(sys_cnt)
  );

  syn_syscall #(.DISP_HOLD(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .v0(v0), .a0(a0), .resume(resume),
    .stall(stall2), .halted(halted2), .disp_val(disp_val2), .disp_we(disp_we2),
    .sys_cnt(sys_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("pass %s: %h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  // One-cycle syscall retire strobe.
  task automatic sys(input logic [31:0] code, input logic [31:0] arg);
    v0 = code;
    a0 = arg;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b0;
    v0 = '0;
    a0 = '0;
    resume = 1'b0;
    tick();
    tick();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_disp_val", disp_val, 32'd0);
    chk("rst_disp_we", 32'(disp_we), 32'd0);
    chk("rst_sys_cnt", 32'(sys_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Display syscall: 4 stall cycles, one disp_we pulse.
    sys(32'd1, 32'h0000_002A);
    chk("disp_we_pulse", 32'(disp_we), 32'd1);
    chk("disp_val", disp_val, 32'h0000_002A);
    chk("disp_cnt", 32'(sys_cnt), 32'd1);
    nst = 0;
    for (int i = 0; i < 8; i++) begin
      if (stall) nst++;
      tick();
      if (i == 0) chk("disp_we_drop", 32'(disp_we), 32'd0);
    end
    chk("disp_stall_len", 32'(nst), 32'd4);
    chk("disp_stall_end", 32'(stall), 32'd0);

    // Pause: accepted with resume also high in IDLE (resume ignored).
    do_reset();
    resume = 1'b1;
    sys(32'd50, 32'd0);
    resume = 1'b0;
    chk("pause_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        v0 = 32'd5;
        en = 1'b1;
      end else begin
        en = 1'b0;
      end
      tick();
    end
    en = 1'b0;
    chk("pause_held", 32'(stall), 32'd1);
    chk("pause_en_ignored", 32'(sys_cnt), 32'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("pause_released", 32'(stall), 32'd0);
    // en and resume together in PAUSE: resume wins, exit code not accepted.
    sys(32'd50, 32'd0);
    chk("pause2_cnt", 32'(sys_cnt), 32'd2);
    v0 = 32'd10;
    en = 1'b1;
    resume = 1'b1;
    tick();
    en = 1'b0;
    resume = 1'b0;
    chk("pause2_stall", 32'(stall), 32'd0);
    chk("pause2_halted", 32'(halted), 32'd0);
    chk("pause2_cnt_hold", 32'(sys_cnt), 32'd2);

    // Exit: terminal until reset.
    do_reset();
    sys(32'd10, 32'd0);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_stall", 32'(stall), 32'd1);
    sys(32'd1, 32'h55);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tick();
    chk("halt_persist", 32'(halted), 32'd1);
    chk("halt_stall_persist", 32'(stall), 32'd1);
    chk("halt_cnt", 32'(sys_cnt), 32'd1);
    chk("halt_no_disp", disp_val, 32'd0);
    rst = 1'b1;
    #1;
    chk("halt_rst_halted", 32'(halted), 32'd0);
    chk("halt_rst_stall", 32'(stall), 32'd0);
    chk("halt_rst_cnt", 32'(sys_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Other codes only count; full 32-bit compare on v0.
    sys(32'd5, 32'd0);
    chk("other1_stall", 32'(stall), 32'd0);
    sys(32'd5, 32'd0);
    chk("other2_we", 32'(disp_we), 32'd0);
    sys(32'h0001_000A, 32'd0);
    chk("other3_stall", 32'(stall), 32'd0);
    chk("other3_halted", 32'(halted), 32'd0);
    chk("other_cnt", 32'(sys_cnt), 32'd3);
    chk("sat_cnt3", 32'(sys_cnt2), 32'd3);
    sys(32'd5, 32'd0);
    chk("other_cnt4", 32'(sys_cnt), 32'd4);
    chk("sat_cnt4", 32'(sys_cnt2), 32'd3);

    // Async reset in the middle of a display hold.
    do_reset();
    sys(32'd34, 32'h0000_1234);
    chk("disp34_val", disp_val, 32'h0000_1234);
    tick();
    chk("disp34_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_disp_val", disp_val, 32'd0);
    chk("abort_disp_we", 32'(disp_we), 32'd0);
    rst = 1'b0;
    tick();
    sys(32'd1, 32'h0000_0007);
    chk("after_abort_we", 32'(disp_we), 32'd1);
    chk("after_abort_val", disp_val, 32'h0000_0007);
    chk("after_abort_cnt", 32'(sys_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
